pipo_universal_shreg: RTL and testbench

- Parametrised successor to the 4-bit PIPO register: WIDTH-bit register with parallel load, shift, rotate and clear modes.
- Adds an autonomous serialiser engine: a `start` pulse loads `pin`, then shifts WIDTH times and reports `done`.
- Sits between parallel datapath registers and serial links; the same block serves as PIPO, PISO, SIPO or SISO depending on mode.

---
 rtl/pipo_pkg.sv | 23 ++
 rtl/pipo_shift_core.sv | 29 ++
 rtl/pipo_universal_shreg.sv | 102 ++++++++++
 tb/tb_pipo_universal_shreg.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipo_pkg.sv
// rtl/pipo_pkg.sv - shared mode codes and burst FSM encoding for the universal shift register
package pipo_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROTL = 3'b100;
  localparam logic [2:0] MODE_ROTR = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // A burst is a plain shift in the latched direction: left ejects the MSB, right the LSB.
  function automatic logic [2:0] burst_op(input logic dir);
    return dir ? MODE_SHR : MODE_SHL;
  endfunction

endpackage

// File: rtl/pipo_shift_core.sv
// rtl/pipo_shift_core.sv - combinational next-q function for all register operations
module pipo_shift_core
  import pipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [2:0]       op_i,
  input  logic             sin_l_i,
  input  logic             sin_r_i,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] q_next_o
);

  // Decode one operation; the reserved code and any unknown code hold q.
  always_comb begin
    q_next_o = q_i;
    case (op_i)
      MODE_LOAD: q_next_o = pin_i;
      MODE_SHL:  q_next_o = {q_i[WIDTH-2:0], sin_r_i};
      MODE_SHR:  q_next_o = {sin_l_i, q_i[WIDTH-1:1]};
      MODE_ROTL: q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_ROTR: q_next_o = {q_i[0], q_i[WIDTH-1:1]};
      MODE_CLR:  q_next_o = '0;
      default:   q_next_o = q_i;
    endcase
  end

endmodule

// File: rtl/pipo_universal_shreg.sv
// rtl/pipo_universal_shreg.sv - WIDTH-bit universal shift register with autonomous serialiser burst
module pipo_universal_shreg
  import pipo_pkg::*;
#(
  parameter int  WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] pin_i,
  input  logic             sin_r_i,
  input  logic             sin_l_i,
  input  logic             start_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] q_o,
  output logic             sout_l_o,
  output logic             sout_r_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] shift_cnt_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [2:0]       op;
  logic [WIDTH-1:0] core_q;

  pipo_shift_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .q_i     (q_q),
    .op_i    (op),
    .sin_l_i (sin_l_i),
    .sin_r_i (sin_r_i),
    .pin_i   (pin_i),
    .q_next_o(core_q)
  );

  // Next-state logic: manual ops only in IDLE, start wins over mode, burst ignores all requests.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    op      = MODE_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          q_d     = pin_i;
          dir_d   = dir_i;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          op  = mode_i;
          q_d = core_q;
        end
      end
      ST_SHIFT: begin
        op    = burst_op(dir_q);
        q_d   = core_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any burst without producing done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  assign q_o         = q_q;
  assign sout_l_o    = q_q[WIDTH-1];
  assign sout_r_o    = q_q[0];
  assign busy_o      = (state_q == ST_SHIFT);
  assign done_o      = (state_q == ST_DONE);
  assign shift_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipo_universal_shreg.sv
// tb/tb_pipo_universal_shreg.sv - scoreboard bench for the universal shift register and serialiser
module tb_pipo_universal_shreg;

  logic       clk;
  logic       rst_n;
  logic [2:0] mode;
  logic       sin_r, sin_l, dir;

  logic [3:0] pin4, q4;
  logic       start4, soutl4, soutr4, busy4, done4;
  logic [2:0] cnt4;

  logic [7:0] pin8, q8;
  logic       start8, soutl8, soutr8, busy8, done8;
  logic [3:0] cnt8;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [3:0] q_exp[$];
  logic       ser_exp[$];

  pipo_universal_shreg #(.WIDTH(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .pin_i(pin4), .sin_r_i(sin_r), .sin_l_i(sin_l),
    .start_i(start4), .dir_i(dir), .q_o(q4), .sout_l_o(soutl4), .sout_r_o(soutr4),
    .busy_o(busy4), .done_o(done4), .shift_cnt_o(cnt4)
  );

  pipo_universal_shreg #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .pin_i(pin8), .sin_r_i(sin_r), .sin_l_i(sin_l),
    .start_i(start8), .dir_i(dir), .q_o(q8), .sout_l_o(soutl8), .sout_r_o(soutr8),
    .busy_o(busy8), .done_o(done8), .shift_cnt_o(cnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    #1;
    total_cnt++;
    if ({q4, busy4, done4, cnt4} !== 9'b0) $display("FAIL reset_init: got q=%b busy=%b done=%b cnt=%0d want 0", q4, busy4, done4, cnt4);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mode = 3'b001;
    pin4 = 4'hA;
    @(negedge clk);
    mode = 3'b000;
    total_cnt++;
    if (q4 !== 4'hA) $display("FAIL reset_preload: got q=%h want a", q4);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({q4, busy4, done4} !== 6'b0) $display("FAIL reset_async: got q=%b busy=%b done=%b want 0", q4, busy4, done4);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_manual();
    logic [2:0] m  [10];
    logic [3:0] p  [10];
    logic [1:0] s  [10];
    logic [3:0] e  [10];
    logic [3:0] got, want;
    m = '{3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b001, 3'b111, 3'b000, 3'b011};
    p = '{4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0110, 4'b1111, 4'b1111, 4'b0000};
    // s = {sin_l, sin_r}
    s = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b01, 2'b11, 2'b00, 2'b11, 2'b11, 2'b10};
    e = '{4'b1001, 4'b0011, 4'b1001, 4'b0011, 4'b0001, 4'b0000, 4'b0110, 4'b0110, 4'b0110, 4'b1011};
    for (int i = 0; i < 10; i++) begin
      mode  = m[i];
      pin4  = p[i];
      sin_l = s[i][1];
      sin_r = s[i][0];
      q_exp.push_back(e[i]);
      @(negedge clk);
      want = q_exp.pop_front();
      got  = q4;
      total_cnt++;
      if (got !== want) $display("FAIL manual_%0d mode=%b: got q=%b want %b", i, m[i], got, want);
      else pass_cnt++;
    end
    mode = 3'b000;
    sin_l = 1'b0;
    sin_r = 1'b0;
  endtask

  // Runs one 4-bit burst; with collide set, load/clear/start are hammered throughout.
  task automatic run_burst4(input string name, input logic [3:0] p, input logic d,
                            input logic fill, input logic [3:0] final_q, input logic collide);
    int   dones = 0;
    logic want, got;
    pin4  = p;
    dir   = d;
    sin_r = d ? 1'b0 : fill;
    sin_l = d ? fill : 1'b0;
    start4 = 1'b1;
    mode  = collide ? 3'b001 : 3'b000;
    for (int i = 0; i < 4; i++) ser_exp.push_back(d ? p[i] : p[3-i]);
    @(negedge clk);
    if (collide) begin
      mode = 3'b110;
      pin4 = ~p;
    end else begin
      start4 = 1'b0;
    end
    for (int c = 1; c <= 6; c++) begin
      if (done4 === 1'b1) dones++;
      if (c <= 4) begin
        want = ser_exp.pop_front();
        got  = d ? soutr4 : soutl4;
        total_cnt++;
        if (got !== want || busy4 !== 1'b1 || done4 !== 1'b0)
          $display("FAIL %s_shift%0d: got sout=%b busy=%b done=%b want sout=%b busy=1 done=0", name, c, got, busy4, done4, want);
        else pass_cnt++;
      end else if (c == 5) begin
        total_cnt++;
        if (done4 !== 1'b1 || busy4 !== 1'b0 || q4 !== final_q || cnt4 !== 3'd4)
          $display("FAIL %s_done: got done=%b busy=%b q=%b cnt=%0d want 1 0 %b 4", name, done4, busy4, q4, cnt4, final_q);
        else pass_cnt++;
        start4 = 1'b0;
        mode   = 3'b000;
      end else begin
        total_cnt++;
        if (done4 !== 1'b0 || busy4 !== 1'b0 || q4 !== final_q || cnt4 !== 3'd4)
          $display("FAIL %s_after: got done=%b busy=%b q=%b cnt=%0d want 0 0 %b 4", name, done4, busy4, q4, cnt4, final_q);
        else pass_cnt++;
      end
      @(negedge clk);
    end
    total_cnt++;
    if (dones != 1 || busy4 !== 1'b0) $display("FAIL %s_pulses: got %0d done pulses busy=%b want 1 busy=0", name, dones, busy4);
    else pass_cnt++;
  endtask

  task automatic test_left_burst();
    run_burst4("left", 4'b1011, 1'b0, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic test_right_burst();
    run_burst4("right", 4'b0110, 1'b1, 1'b1, 4'b1111, 1'b0);
  endtask

  task automatic test_collision();
    run_burst4("collide", 4'b0110, 1'b1, 1'b1, 4'b1111, 1'b1);
  endtask

  task automatic test_abort();
    int dones = 0;
    pin4   = 4'b1011;
    dir    = 1'b0;
    sin_r  = 1'b0;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (q4 !== 4'b1100 || cnt4 !== 3'd2 || busy4 !== 1'b1)
      $display("FAIL abort_mid: got q=%b cnt=%0d busy=%b want 1100 2 1", q4, cnt4, busy4);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (q4 !== 4'b0 || busy4 !== 1'b0 || done4 !== 1'b0 || cnt4 !== 3'd0)
      $display("FAIL abort_reset: got q=%b busy=%b done=%b cnt=%0d want 0", q4, busy4, done4, cnt4);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done4 !== 1'b0 || busy4 !== 1'b0) dones++;
    end
    total_cnt++;
    if (dones != 0) $display("FAIL abort_nodone: got %0d active cycles want 0", dones);
    else pass_cnt++;
  endtask

  task automatic test_width8();
    logic want;
    int   dones = 0;
    pin8   = 8'hB5;
    dir    = 1'b0;
    sin_r  = 1'b0;
    start8 = 1'b1;
    for (int i = 7; i >= 0; i--) ser_exp.push_back(pin8[i]);
    @(negedge clk);
    start8 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (done8 === 1'b1) dones++;
      if (c <= 8) begin
        want = ser_exp.pop_front();
        total_cnt++;
        if (soutl8 !== want || busy8 !== 1'b1 || done8 !== 1'b0)
          $display("FAIL w8_shift%0d: got sout=%b busy=%b done=%b want sout=%b busy=1 done=0", c, soutl8, busy8, done8, want);
        else pass_cnt++;
      end else if (c == 9) begin
        total_cnt++;
        if (done8 !== 1'b1 || busy8 !== 1'b0 || q8 !== 8'h00 || cnt8 !== 4'd8)
          $display("FAIL w8_done: got done=%b busy=%b q=%h cnt=%0d want 1 0 00 8", done8, busy8, q8, cnt8);
        else pass_cnt++;
      end
      @(negedge clk);
    end
    total_cnt++;
    if (dones != 1) $display("FAIL w8_pulses: got %0d done pulses want 1", dones);
    else pass_cnt++;
  endtask

  initial begin
    rst_n  = 1'b0;
    mode   = 3'b000;
    sin_r  = 1'b0;
    sin_l  = 1'b0;
    dir    = 1'b0;
    pin4   = 4'h0;
    start4 = 1'b0;
    pin8   = 8'h00;
    start8 = 1'b0;
    test_reset();
    test_manual();
    test_left_burst();
    test_right_burst();
    test_collision();
    test_abort();
    test_width8();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
